hr_4t16_demux_top: RTL and testbench

Half-rate 4:16 deserializer with word alignment: the receive-side counterpart of the 16:4 transmit mux. Collects four consecutive 4-bit beats into one 16-bit word. Locates the word boundary by bit-slipping against a training pattern and flags lock. Sits between the 4-lane receive slicers/retimers and the PRBS checker or downstream word logic.

---
 rtl/hr_4t16_demux_if.sv | 23 ++
 rtl/hr_4t16_demux_top.sv | 147 ++++++++++++++
 tb/tb_hr_4t16_demux_top.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hr_4t16_demux_if.sv
// Receive-side bus of the half-rate 4:16 deserializer.
// master = beat source / word consumer, slave = deserializer.
interface hr_4t16_demux_if #(
   parameter int NUM_LANES = 4,
   parameter int VEC_W     = 16
);
   logic [NUM_LANES-1:0] din;
   logic                 align_en;
   logic [VEC_W-1:0]     dout;
   logic                 dout_valid;
   logic                 locked;
   logic [1:0]           slip_cnt;

   modport master (
      output din, align_en,
      input  dout, dout_valid, locked, slip_cnt
   );

   modport slave (
      input  din, align_en,
      output dout, dout_valid, locked, slip_cnt
   );
endinterface

// File: rtl/hr_4t16_demux_top.sv
// Half-rate 4:16 deserializer: gathers four 4-bit beats into a 16-bit word
// and finds the word boundary by beat-slipping against a training pattern.

// One lane: keeps the three earlier beats of the current frame; the nibble
// presented is those beats plus the live bit, with bit k = beat k.
module hr_4t16_lane (
   input  logic       clk_hr,
   input  logic       rst_n,
   input  logic       bit_in,
   input  logic       shift_en,
   output logic [3:0] nib
);
   logic [2:0] sr;

   always_ff @(posedge clk_hr or negedge rst_n) begin
      if (!rst_n)        sr <= '0;
      else if (shift_en) sr <= {bit_in, sr[2:1]};
   end

   assign nib = {bit_in, sr};
endmodule

module hr_4t16_demux_top #(
   parameter logic [15:0] ALIGN_PATTERN = 16'h8421,
   parameter int          LOCK_CNT      = 4,
   parameter int          UNLOCK_CNT    = 4
) (
   input  logic            clk_hr,
   input  logic            rst_n,
   hr_4t16_demux_if.slave  bus
);
   localparam int NUM_LANES = 4;
   localparam int BEATS     = 4;
   localparam logic [3:0] LOCK_N   = LOCK_CNT[3:0];
   localparam logic [3:0] UNLOCK_N = UNLOCK_CNT[3:0];

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   state_t     state;
   logic [1:0] beat_cnt;
   logic [3:0] mcnt;
   logic       slip_pend;
   logic [1:0] slip_cnt_q;
   logic       locked_q;
   logic       dout_valid_q;
   logic [15:0] dout_q;

   logic [NUM_LANES-1:0][BEATS-1:0] lane_nib;
   logic [15:0] candidate;
   logic        boundary;
   logic        match;

   // The discarded beat after a slip must not enter the history.
   for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
      hr_4t16_lane u_lane (
         .clk_hr   (clk_hr),
         .rst_n    (rst_n),
         .bit_in   (bus.din[j]),
         .shift_en (!slip_pend),
         .nib      (lane_nib[j])
      );
   end

   // Lane j occupies word bits [4j+3:4j], so the packed array is the word.
   assign candidate = lane_nib;
   assign boundary  = (beat_cnt == 2'd3) && !slip_pend;
   assign match     = (candidate == ALIGN_PATTERN);

   always_ff @(posedge clk_hr or negedge rst_n) begin
      if (!rst_n) begin
         state        <= SEARCH;
         beat_cnt     <= '0;
         mcnt         <= '0;
         slip_pend    <= 1'b0;
         slip_cnt_q   <= '0;
         locked_q     <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_q       <= '0;
      end else begin
         dout_valid_q <= 1'b0;
         if (slip_pend) begin
            slip_pend <= 1'b0;
         end else begin
            beat_cnt <= beat_cnt + 2'd1;
            if (boundary) begin
               dout_q       <= candidate;
               dout_valid_q <= 1'b1;
               if (bus.align_en) begin
                  case (state)
                     SEARCH: begin
                        if (match) begin
                           if (LOCK_N == 4'd1) begin
                              state    <= LOCKED;
                              locked_q <= 1'b1;
                              mcnt     <= '0;
                           end else begin
                              state <= VERIFY;
                              mcnt  <= 4'd1;
                           end
                        end else begin
                           slip_pend  <= 1'b1;
                           slip_cnt_q <= slip_cnt_q + 2'd1;
                        end
                     end
                     VERIFY: begin
                        if (match) begin
                           if (mcnt + 4'd1 == LOCK_N) begin
                              state    <= LOCKED;
                              locked_q <= 1'b1;
                              mcnt     <= '0;
                           end else begin
                              mcnt <= mcnt + 4'd1;
                           end
                        end else begin
                           state <= SEARCH;
                           mcnt  <= '0;
                        end
                     end
                     LOCKED: begin
                        // mcnt doubles as the consecutive-mismatch run here.
                        if (match) begin
                           mcnt <= '0;
                        end else if (mcnt + 4'd1 == UNLOCK_N) begin
                           state    <= SEARCH;
                           locked_q <= 1'b0;
                           mcnt     <= '0;
                        end else begin
                           mcnt <= mcnt + 4'd1;
                        end
                     end
                     default: begin
                        state    <= SEARCH;
                        locked_q <= 1'b0;
                        mcnt     <= '0;
                     end
                  endcase
               end
            end
         end
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.locked     = locked_q;
   assign bus.slip_cnt   = slip_cnt_q;
endmodule

// File: tb/tb_hr_4t16_demux_top.sv
// Directed + randomized bench for hr_4t16_demux_top against a beat-stream
// reference model of the word-alignment rules.
module tb_hr_4t16_demux_top;
   localparam logic [15:0] PAT = 16'h8421;
   localparam int LOCK_CNT   = 4;
   localparam int UNLOCK_CNT = 4;
   localparam int M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;

   logic clk_hr = 1'b0;
   logic rst_n  = 1'b0;
   always #5 clk_hr = ~clk_hr;

   hr_4t16_demux_if bus ();

   hr_4t16_demux_top #(
      .ALIGN_PATTERN (PAT),
      .LOCK_CNT      (LOCK_CNT),
      .UNLOCK_CNT    (UNLOCK_CNT)
   ) dut (
      .clk_hr (clk_hr),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [3:0]  m_beats [4];
   int          m_pos;
   bit          m_discard;
   int          m_state;
   int          m_run;
   int          m_slips;
   logic [15:0] m_dout;
   logic        m_valid;

   int cyc    = 0;
   int last_v = -1;
   int gap5   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] beat_of(input logic [15:0] w, input int k);
      logic [3:0] b;
      for (int j = 0; j < 4; j++) b[j] = w[4*j+k];
      return b;
   endfunction

   task automatic m_reset();
      m_pos = 0; m_discard = 0; m_state = M_SEARCH; m_run = 0;
      m_slips = 0; m_dout = '0; m_valid = 1'b0;
      for (int k = 0; k < 4; k++) m_beats[k] = '0;
   endtask

   task automatic m_edge(input logic [3:0] d, input logic ae);
      logic [15:0] w;
      bit match;
      m_valid = 1'b0;
      if (m_discard) begin
         m_discard = 0;
         return;
      end
      m_beats[m_pos] = d;
      if (m_pos < 3) begin
         m_pos++;
         return;
      end
      m_pos = 0;
      for (int j = 0; j < 4; j++)
         for (int k = 0; k < 4; k++) w[4*j+k] = m_beats[k][j];
      m_dout  = w;
      m_valid = 1'b1;
      match   = (w == PAT);
      if (!ae) return;
      if (m_state == M_SEARCH) begin
         if (match) begin
            m_run   = (LOCK_CNT == 1) ? 0 : 1;
            m_state = (LOCK_CNT == 1) ? M_LOCKED : M_VERIFY;
         end else begin
            m_discard = 1;
            m_slips   = (m_slips + 1) % 4;
         end
      end else if (m_state == M_VERIFY) begin
         if (match) begin
            m_run++;
            if (m_run == LOCK_CNT) begin m_state = M_LOCKED; m_run = 0; end
         end else begin
            m_state = M_SEARCH; m_run = 0;
         end
      end else begin
         m_run = match ? 0 : m_run + 1;
         if (m_run == UNLOCK_CNT) begin m_state = M_SEARCH; m_run = 0; end
      end
   endtask

   // Called #1 after a rising edge; drives, advances one edge, checks.
   task automatic step(input logic [3:0] d, input logic ae);
      bus.din = d;
      bus.align_en = ae;
      @(posedge clk_hr);
      m_edge(d, ae);
      cyc++;
      #1;
      chk("dout_valid", bus.dout_valid, m_valid);
      chk("dout", bus.dout, m_dout);
      chk("locked", bus.locked, m_state == M_LOCKED);
      chk("slip_cnt", bus.slip_cnt, m_slips[1:0]);
      if (bus.dout_valid) begin
         if (last_v >= 0 && cyc - last_v == 5) gap5++;
         last_v = cyc;
      end
   endtask

   task automatic send_word(input logic [15:0] w, input logic ae);
      for (int k = 0; k < 4; k++) step(beat_of(w, k), ae);
   endtask

   // Asserted mid-cycle to show the reset is asynchronous.
   task automatic do_reset();
      #3 rst_n = 1'b0;
      #1;
      chk("rst_dout", bus.dout, 16'h0);
      chk("rst_valid", bus.dout_valid, 1'b0);
      chk("rst_locked", bus.locked, 1'b0);
      chk("rst_slip", bus.slip_cnt, 2'd0);
      m_reset();
      @(posedge clk_hr);
      #1 rst_n = 1'b1;
      last_v = -1;
   endtask

   initial begin
      int n, v0, nslip;
      logic [1:0] slips_seen [4];
      logic [15:0] w;
      bus.din = '0;
      bus.align_en = 1'b0;
      m_reset();

      // power-on reset
      repeat (2) @(posedge clk_hr);
      #1;
      chk("por_dout", bus.dout, 16'h0);
      chk("por_valid", bus.dout_valid, 1'b0);
      chk("por_locked", bus.locked, 1'b0);
      chk("por_slip", bus.slip_cnt, 2'd0);
      rst_n = 1'b1;

      // aligned training
      for (int i = 0; i < 4; i++) send_word(PAT, 1'b1);
      chk("aligned_locked", bus.locked, 1'b1);
      chk("aligned_slip", bus.slip_cnt, 2'd0);
      chk("aligned_dout", bus.dout, PAT);
      send_word(PAT, 1'b1);

      // reset while locked, then first valid 4 edges after release
      do_reset();
      n = 0;
      for (int i = 1; i <= 10 && n == 0; i++) begin
         step(4'($urandom), 1'b0);
         if (bus.dout_valid) n = i;
      end
      chk("first_valid_edge", n, 4);

      // offset 2: pattern beat 0 first appears on the third edge
      do_reset();
      gap5 = 0;
      for (int t = 0; t < 30; t++) step(beat_of(PAT, (t + 2) % 4), 1'b1);
      chk("off2_slip", bus.slip_cnt, 2'd2);
      chk("off2_locked", bus.locked, 1'b1);
      chk("off2_gap5", gap5, 2);

      // payload after lock with training off
      send_word(16'h1234, 1'b0);
      chk("data0_valid", bus.dout_valid, 1'b1);
      chk("data0", bus.dout, 16'h1234);
      v0 = last_v;
      send_word(16'hBEEF, 1'b0);
      chk("data1_valid", bus.dout_valid, 1'b1);
      chk("data1", bus.dout, 16'hBEEF);
      chk("data_gap", last_v - v0, 4);
      chk("data_locked", bus.locked, 1'b1);
      chk("data_slip", bus.slip_cnt, 2'd2);

      // loss of lock
      for (int i = 0; i < 3; i++) send_word(16'h1234, 1'b1);
      send_word(PAT, 1'b1);
      chk("lol_hold", bus.locked, 1'b1);
      for (int i = 0; i < 3; i++) send_word(16'h1234, 1'b1);
      chk("lol_3mis", bus.locked, 1'b1);
      send_word(16'h1234, 1'b1);
      chk("lol_4mis", bus.locked, 1'b0);
      chk("lol_noslip", bus.slip_cnt, 2'd2);

      // slip wrap with no pattern ever present
      do_reset();
      nslip = 0;
      for (int i = 0; i < 30 && nslip < 4; i++) begin
         step(4'h0, 1'b1);
         if (bus.dout_valid) begin
            slips_seen[nslip] = bus.slip_cnt;
            nslip++;
         end
      end
      chk("wrap_count", nslip, 4);
      for (int i = 0; i < 4; i++) begin
         logic [1:0] e;
         e = 2'((i + 1) % 4);
         chk("wrap_slip", slips_seen[i], e);
      end
      chk("wrap_locked", bus.locked, 1'b0);

      // randomized traffic: mixed pattern/random words, occasional extra beats
      do_reset();
      for (int i = 0; i < 200; i++) begin
         logic ae;
         ae = ($urandom_range(0, 9) != 0);
         w = ($urandom_range(0, 2) != 0) ? PAT : 16'($urandom);
         send_word(w, ae);
         if ($urandom_range(0, 11) == 0) step(4'($urandom), ae);
         if ($urandom_range(0, 99) == 0) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
